// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
// Channel encoding follows LRCK: low selects the left slot.
package i2s_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SHIFT = 2'd1,
        PAD   = 2'd2
    } rx_state_t;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    localparam int DATA_W_DEF = 16;

    // Bit counter must be able to hold DATA_W itself.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/i2s_if.sv
// Bundle of the codec-facing I2S pins and the received PCM pair.
// The master drives the serial side; the slave is the receiver.
interface i2s_if #(
    parameter int DATA_W = 16
);
    logic              sclk;
    logic              lrck;
    logic              sdout;
    logic              err_clr;
    logic [DATA_W-1:0] l_data;
    logic [DATA_W-1:0] r_data;
    logic              sample_valid;
    logic              frame_err;

    // sample_valid is a one-cycle strobe: l_data/r_data are a new pair only
    // in the cycle it is high and hold their value otherwise; there is no ready.
    modport master (
        output sclk, lrck, sdout, err_clr,
        input  l_data, r_data, sample_valid, frame_err
    );

    modport slave (
        input  sclk, lrck, sdout, err_clr,
        output l_data, r_data, sample_valid, frame_err
    );
endinterface

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with a rising-edge
// detector on the synchronised level. STAGES must be at least 2.
module i2s_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: samples SCK/LRCK/SDOUT in the system clock domain and
// publishes 16-bit left/right PCM pairs with a single-cycle valid strobe.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              iCLK_50,
    input  logic              iRESET_n,
    input  logic              dac_SCLK,
    input  logic              dac_LRCK,
    input  logic              adc_SDOUT,
    input  logic              err_clr,
    output logic [DATA_W-1:0] L_data,
    output logic [DATA_W-1:0] R_data,
    output logic              sample_valid,
    output logic              frame_err
);
    localparam int CNT_W = cnt_width(DATA_W);

    logic sck_rise, lr_s, d_s;
    logic sck_lvl_unused, lr_rise_unused, sd_rise_unused;

    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk_i (iCLK_50), .rst_ni (iRESET_n), .d_i (dac_SCLK),
        .q_o   (sck_lvl_unused), .rise_o (sck_rise)
    );

    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lr (
        .clk_i (iCLK_50), .rst_ni (iRESET_n), .d_i (dac_LRCK),
        .q_o   (lr_s), .rise_o (lr_rise_unused)
    );

    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sd (
        .clk_i (iCLK_50), .rst_ni (iRESET_n), .d_i (adc_SDOUT),
        .q_o   (d_s), .rise_o (sd_rise_unused)
    );

    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] l_hold_q, l_hold_d;
    logic [DATA_W-1:0] l_data_q, l_data_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              chan_q, chan_d;
    logic              lr_prev_q, lr_prev_d;
    logic              lr_seen_q, lr_seen_d;
    logic              l_vld_q, l_vld_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic              lr_chg;
    logic              short_slot;
    logic [DATA_W-1:0] word_next;

    // lr_prev is meaningless until the first sampled edge after reset, so the
    // slot in progress at reset release can never look like a slot start.
    assign lr_chg    = lr_seen_q && (lr_s != lr_prev_q);
    assign word_next = {shreg_q[DATA_W-2:0], d_s};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        l_hold_d   = l_hold_q;
        l_data_d   = l_data_q;
        r_data_d   = r_data_q;
        chan_d     = chan_q;
        lr_prev_d  = lr_prev_q;
        lr_seen_d  = lr_seen_q;
        l_vld_d    = l_vld_q;
        valid_d    = 1'b0;
        short_slot = 1'b0;

        if (sck_rise) begin
            lr_prev_d = lr_s;
            lr_seen_d = 1'b1;
            case (state_q)
                HUNT, PAD: begin
                    if (lr_chg) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                        shreg_d = '0;
                        chan_d  = lr_s;
                    end
                end
                SHIFT: begin
                    if (lr_chg) begin
                        // Slot ended before a full word: drop it and its pending pair.
                        short_slot = 1'b1;
                        if (chan_q == LEFT) l_vld_d = 1'b0;
                        cnt_d   = '0;
                        shreg_d = '0;
                        chan_d  = lr_s;
                    end else begin
                        shreg_d = word_next;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            state_d = PAD;
                            cnt_d   = '0;
                            if (chan_q == LEFT) begin
                                l_hold_d = word_next;
                                l_vld_d  = 1'b1;
                            end else if (l_vld_q) begin
                                l_data_d = l_hold_q;
                                r_data_d = word_next;
                                valid_d  = 1'b1;
                                l_vld_d  = 1'b0;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // A short slot in the same cycle as a clear request keeps the flag set.
        err_d = err_q;
        if (err_clr)    err_d = 1'b0;
        if (short_slot) err_d = 1'b1;
    end

    always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
        if (!iRESET_n) begin
            state_q   <= HUNT;
            cnt_q     <= '0;
            shreg_q   <= '0;
            l_hold_q  <= '0;
            l_data_q  <= '0;
            r_data_q  <= '0;
            chan_q    <= LEFT;
            lr_prev_q <= 1'b0;
            lr_seen_q <= 1'b0;
            l_vld_q   <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            l_hold_q  <= l_hold_d;
            l_data_q  <= l_data_d;
            r_data_q  <= r_data_d;
            chan_q    <= chan_d;
            lr_prev_q <= lr_prev_d;
            lr_seen_q <= lr_seen_d;
            l_vld_q   <= l_vld_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign L_data       = l_data_q;
    assign R_data       = r_data_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: a codec model drives I2S slots while a monitor
// records every published pair against a queue of expected pairs.
module tb_i2s_rx;
    import i2s_pkg::*;

    localparam int DW   = 16;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst_n;

    i2s_if #(.DATA_W(DW)) bus ();

    always #10 clk = ~clk;

    i2s_rx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .iCLK_50      (clk),
        .iRESET_n     (rst_n),
        .dac_SCLK     (bus.sclk),
        .dac_LRCK     (bus.lrck),
        .adc_SDOUT    (bus.sdout),
        .err_clr      (bus.err_clr),
        .L_data       (bus.l_data),
        .R_data       (bus.r_data),
        .sample_valid (bus.sample_valid),
        .frame_err    (bus.frame_err)
    );

    logic [2*DW-1:0] exp_q[$];
    logic [2*DW-1:0] got_q[$];
    int n_cmp    = 0;
    int n_err    = 0;
    int rd_idx   = 0;
    int n_pushed = 0;

    // Every strobe cycle is recorded; a stretched pulse shows up as an extra pair.
    always @(negedge clk) begin
        if (bus.sample_valid === 1'b1) got_q.push_back({bus.l_data, bus.r_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One SCK period: data and LRCK change with SCK low, DUT samples on the rise.
    // With clr set, err_clr is pulsed in the cycle the DUT acts on this rise.
    task automatic send_bit(input logic lr, input logic d, input bit clr);
        @(negedge clk);
        bus.sclk  = 1'b0;
        bus.lrck  = lr;
        bus.sdout = d;
        repeat (HALF - 1) @(negedge clk);
        @(negedge clk);
        bus.sclk = 1'b1;
        if (clr) begin
            repeat (2) @(negedge clk);
            bus.err_clr = 1'b1;
            @(negedge clk);
            bus.err_clr = 1'b0;
            repeat (HALF - 4) @(negedge clk);
        end else begin
            repeat (HALF - 1) @(negedge clk);
        end
    endtask

    // Slot = LRCK-change bit (previous slot) + nbits data/pad bits, MSB first.
    task automatic send_slot(input logic chan, input logic [DW-1:0] word,
                             input int nbits, input bit clr_first);
        send_bit(chan, 1'b1, clr_first);
        for (int i = 0; i < nbits; i++)
            send_bit(chan, (i < DW) ? word[DW-1-i] : 1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input int nbits, input bit expect_pair);
        send_slot(LEFT, l, nbits, 1'b0);
        send_slot(RIGHT, r, nbits, 1'b0);
        if (expect_pair) begin
            exp_q.push_back({l, r});
            n_pushed++;
        end
    endtask

    task automatic drain(input string tag);
        logic [2*DW-1:0] e;
        repeat (4) @(negedge clk);
        check({tag, "_pulse_count"}, 32'(got_q.size()), 32'(n_pushed));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_idx < got_q.size()) begin
                check({tag, "_pair"}, got_q[rd_idx], e);
                rd_idx++;
            end
        end
    endtask

    task automatic check_outputs(input string tag, input logic [DW-1:0] l,
                                 input logic [DW-1:0] r, input logic err);
        check({tag, "_L"}, 32'(bus.l_data), 32'(l));
        check({tag, "_R"}, 32'(bus.r_data), 32'(r));
        check({tag, "_err"}, 32'(bus.frame_err), 32'(err));
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.sclk    = 1'b0;
        bus.lrck    = 1'b0;
        bus.sdout   = 1'b0;
        bus.err_clr = 1'b0;
        repeat (5) @(negedge clk);
        check_outputs("reset", 16'h0000, 16'h0000, 1'b0);
        check("reset_valid", 32'(bus.sample_valid), 32'd0);
        rst_n = 1'b1;

        // Nominal 32-bit slots: the leading right slot only seeds LRCK history.
        send_slot(RIGHT, 16'hDEAD, 31, 1'b0);
        send_frame(16'h1234, 16'hABCD, 31, 1'b1);
        send_frame(16'h1234, 16'hABCD, 31, 1'b1);
        drain("nominal");
        check_outputs("nominal", 16'h1234, 16'hABCD, 1'b0);

        // Exact 16-bit slots.
        send_frame(16'h8001, 16'h7FFE, DW, 1'b1);
        send_frame(16'hFFFF, 16'h0000, DW, 1'b1);
        drain("exact");
        check_outputs("exact", 16'hFFFF, 16'h0000, 1'b0);

        // Short left slot: error, no pair, outputs unchanged.
        send_slot(LEFT, 16'hA500, 8, 1'b0);
        send_slot(RIGHT, 16'h5555, DW, 1'b0);
        drain("short");
        check_outputs("short", 16'hFFFF, 16'h0000, 1'b1);
        send_frame(16'h1111, 16'h2222, 31, 1'b1);
        drain("after_short");
        check_outputs("after_short", 16'h1111, 16'h2222, 1'b1);
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        @(negedge clk);
        check("err_clr", 32'(bus.frame_err), 32'd0);

        // err_clr coincides with short-slot detection: set wins.
        send_slot(LEFT, 16'h3C00, 5, 1'b0);
        send_slot(RIGHT, 16'h4444, DW, 1'b1);
        drain("simul");
        check_outputs("simul", 16'h1111, 16'h2222, 1'b1);

        // Reset after 9 bits of a left word.
        send_bit(LEFT, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) send_bit(LEFT, 1'(i % 2), 1'b0);
        rst_n = 1'b0;
        #1;
        check_outputs("midreset", 16'h0000, 16'h0000, 1'b0);
        check("midreset_valid", 32'(bus.sample_valid), 32'd0);
        for (int i = 9; i < 31; i++) send_bit(LEFT, 1'b1, 1'b0);

        // Release reset in the middle of a right slot.
        send_bit(RIGHT, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(RIGHT, 1'(i % 3 == 0), 1'b0);
        rst_n = 1'b1;
        for (int i = 10; i < 31; i++) send_bit(RIGHT, 1'b0, 1'b0);
        send_frame(16'h3C5A, 16'h0FF0, 31, 1'b1);
        send_frame(16'h1357, 16'h2468, DW, 1'b1);
        drain("restart");
        check_outputs("restart", 16'h1357, 16'h2468, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
